// File: rtl/brsched_pkg.sv
// -----------------------------------------------------------------------------
// brsched_pkg
// Shared constants for the branch-unit issue scheduler.
//   BRSCHED_ENTRY_NUM : default number of scheduler slots
//   BRSCHED_IDX_W     : width of a slot index
//   TAG_W             : width of an RRF source tag
//   SPECTAG_LEN       : width of a one-hot speculation tag / dependency mask
// -----------------------------------------------------------------------------
package brsched_pkg;

    localparam int TAG_W             = 6;
    localparam int SPECTAG_LEN       = 5;
    localparam int BRSCHED_ENTRY_NUM = 4;
    localparam int BRSCHED_IDX_W     = $clog2(BRSCHED_ENTRY_NUM);

    typedef logic [BRSCHED_IDX_W-1:0] brsched_idx_t;

endpackage

// File: rtl/brsched_oldest_sel.sv
// -----------------------------------------------------------------------------
// brsched_oldest_sel
// Combinational oldest-ready picker over an age matrix.
// Row k of age_i has bit j set when live entry j is older than entry k, so the
// oldest ready entry is the ready one whose row has no ready bit set.
// Ports:
//   ready_i  in  N        entries eligible for issue
//   age_i    in  N x N    age matrix (row = entry, bit = older entry)
//   grant_o  out N        one-hot grant (all zero when nothing is ready)
//   idx_o    out IDX_W    encoded grant index (0 when nothing is ready)
// -----------------------------------------------------------------------------
module brsched_oldest_sel
    import brsched_pkg::*;
#(
    parameter int N     = BRSCHED_ENTRY_NUM,
    parameter int IDX_W = BRSCHED_IDX_W
) (
    input  logic [N-1:0]        ready_i,
    input  logic [N-1:0][N-1:0] age_i,
    output logic [N-1:0]        grant_o,
    output logic [IDX_W-1:0]    idx_o
);

    logic [N-1:0]     grant_s;
    logic [IDX_W-1:0] idx_s;

    // Grant the ready entry with no ready older entry, then encode it
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            grant_s[i] = ready_i[i] & ~(|(age_i[i] & ready_i));
        end
        for (int i = 0; i < N; i++) begin
            idx_s = grant_s[i] ? IDX_W'(i) : idx_s;
        end
    end

    assign grant_o = grant_s;
    assign idx_o   = idx_s;

endmodule

// File: rtl/brsched_issue.sv
// -----------------------------------------------------------------------------
// brsched_issue
// Age-ordered scheduler for the single branch execution unit. Holds up to
// ENTRY_NUM branch/jump ops until both sources are ready, then issues the
// oldest ready op (one per cycle). Branch miss squashes dependent entries,
// branch success clears the resolved tag from every dependency mask.
//
// Optional build macro BRSCHED_WAKEUP_BYPASS_EN: readiness also includes
// same-cycle wakeup matches (wakeup-to-issue latency 0 instead of 1).
//
// Ports:
//   clk, reset                        clock, async active-high reset
//   alloc_valid / alloc_ack           dispatch handshake (ack combinational)
//   alloc_src{1,2}_tag / _rdy         incoming op source tags and ready bits
//   alloc_specmask                    branches the incoming op depends on
//   wk_valid, wk_tag0, wk_tag1        two result-tag wakeup ports
//   kill_valid, kill_tag              branch miss, one-hot tag
//   clr_valid, clr_tag                branch success, one-hot tag
//   issue, issue_idx                  registered issue strobe and slot index
//   count, full                       occupancy
// -----------------------------------------------------------------------------
module brsched_issue
    import brsched_pkg::*;
#(
    parameter int ENTRY_NUM   = BRSCHED_ENTRY_NUM,
    parameter int TAG_W       = brsched_pkg::TAG_W,
    parameter int SPECTAG_LEN = brsched_pkg::SPECTAG_LEN,
    localparam int IDX_W      = $clog2(ENTRY_NUM)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    output logic                   alloc_ack,
    input  logic [TAG_W-1:0]       alloc_src1_tag,
    input  logic [TAG_W-1:0]       alloc_src2_tag,
    input  logic                   alloc_src1_rdy,
    input  logic                   alloc_src2_rdy,
    input  logic [SPECTAG_LEN-1:0] alloc_specmask,
    input  logic [1:0]             wk_valid,
    input  logic [TAG_W-1:0]       wk_tag0,
    input  logic [TAG_W-1:0]       wk_tag1,
    input  logic                   kill_valid,
    input  logic [SPECTAG_LEN-1:0] kill_tag,
    input  logic                   clr_valid,
    input  logic [SPECTAG_LEN-1:0] clr_tag,
    output logic                   issue,
    output logic [IDX_W-1:0]       issue_idx,
    output logic [IDX_W:0]         count,
    output logic                   full
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ENTRY_NUM);

    // Registered entry state
    logic [ENTRY_NUM-1:0]                  valid_q, valid_d;
    logic [ENTRY_NUM-1:0][TAG_W-1:0]       src1_tag_q, src1_tag_d;
    logic [ENTRY_NUM-1:0][TAG_W-1:0]       src2_tag_q, src2_tag_d;
    logic [ENTRY_NUM-1:0]                  src1_rdy_q, src1_rdy_d;
    logic [ENTRY_NUM-1:0]                  src2_rdy_q, src2_rdy_d;
    logic [ENTRY_NUM-1:0][SPECTAG_LEN-1:0] specmask_q, specmask_d;
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0]   age_q, age_d;
    logic                                  issue_q, issue_d;
    logic [IDX_W-1:0]                      issue_idx_q, issue_idx_d;
    logic [IDX_W:0]                        count_q, count_d;

    // Combinational helpers
    logic [ENTRY_NUM-1:0]   hit1_s, hit2_s, killed_s, ready_s;
    logic [ENTRY_NUM-1:0]   grant_s, alloc_oh_s;
    logic [IDX_W-1:0]       grant_idx_s, alloc_slot_s;
    logic                   full_s, alloc_killed_s, alloc_ack_s;
    logic                   alloc_rdy1_s, alloc_rdy2_s;
    logic [SPECTAG_LEN-1:0] clr_mask_s;
    logic [IDX_W:0]         kill_cnt_s;

    function automatic logic tag_woken(
        input logic [TAG_W-1:0] tag,
        input logic [1:0]       vld,
        input logic [TAG_W-1:0] tag0,
        input logic [TAG_W-1:0] tag1
    );
        return (vld[0] && (tag == tag0)) || (vld[1] && (tag == tag1));
    endfunction

    // Full comes from registered occupancy only, so a same-cycle issue never frees a slot for alloc
    assign full_s = (count_q == FULL_COUNT);

    // Per-entry wakeup matches, squash hits and issue eligibility
    always_comb begin
        hit1_s   = '0;
        hit2_s   = '0;
        killed_s = '0;
        ready_s  = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            hit1_s[i]   = tag_woken(src1_tag_q[i], wk_valid, wk_tag0, wk_tag1);
            hit2_s[i]   = tag_woken(src2_tag_q[i], wk_valid, wk_tag0, wk_tag1);
            killed_s[i] = valid_q[i] & kill_valid & (|(specmask_q[i] & kill_tag));
`ifdef BRSCHED_WAKEUP_BYPASS_EN
            ready_s[i]  = valid_q[i] & ~killed_s[i] &
                          (src1_rdy_q[i] | hit1_s[i]) & (src2_rdy_q[i] | hit2_s[i]);
`else
            ready_s[i]  = valid_q[i] & ~killed_s[i] & src1_rdy_q[i] & src2_rdy_q[i];
`endif
        end
    end

    brsched_oldest_sel #(
        .N     (ENTRY_NUM),
        .IDX_W (IDX_W)
    ) u_oldest_sel (
        .ready_i (ready_s),
        .age_i   (age_q),
        .grant_o (grant_s),
        .idx_o   (grant_idx_s)
    );

    // Allocation handshake, lowest free slot and incoming-op readiness
    always_comb begin
        alloc_killed_s = kill_valid & (|(alloc_specmask & kill_tag));
        alloc_ack_s    = alloc_valid & ~full_s & ~alloc_killed_s;
        alloc_slot_s   = '0;
        alloc_oh_s     = '0;
        // Scan high to low so the last free slot seen is the lowest index
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            alloc_slot_s = valid_q[i] ? alloc_slot_s : IDX_W'(i);
        end
        for (int i = 0; i < ENTRY_NUM; i++) begin
            alloc_oh_s[i] = alloc_ack_s & (alloc_slot_s == IDX_W'(i));
        end
        alloc_rdy1_s = alloc_src1_rdy | tag_woken(alloc_src1_tag, wk_valid, wk_tag0, wk_tag1);
        alloc_rdy2_s = alloc_src2_rdy | tag_woken(alloc_src2_tag, wk_valid, wk_tag0, wk_tag1);
        clr_mask_s   = clr_valid ? clr_tag : {SPECTAG_LEN{1'b0}};
    end

    // Entry next state: free on issue/kill, load on alloc, otherwise wake and clear
    always_comb begin
        valid_d    = valid_q;
        src1_tag_d = src1_tag_q;
        src2_tag_d = src2_tag_q;
        src1_rdy_d = src1_rdy_q | hit1_s;
        src2_rdy_d = src2_rdy_q | hit2_s;
        specmask_d = specmask_q;
        age_d      = age_q;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            specmask_d[i] = specmask_q[i] & ~clr_mask_s;
            // The newly allocated op is younger than everything: drop its column
            age_d[i]      = age_q[i] & ~alloc_oh_s;
            if (killed_s[i] || grant_s[i]) begin
                valid_d[i] = 1'b0;
            end else if (alloc_oh_s[i]) begin
                valid_d[i]    = 1'b1;
                src1_tag_d[i] = alloc_src1_tag;
                src2_tag_d[i] = alloc_src2_tag;
                src1_rdy_d[i] = alloc_rdy1_s;
                src2_rdy_d[i] = alloc_rdy2_s;
                specmask_d[i] = alloc_specmask & ~clr_mask_s;
                age_d[i]      = valid_q;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Issue register and occupancy update
    always_comb begin
        kill_cnt_s = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            kill_cnt_s = kill_cnt_s + (IDX_W+1)'(killed_s[i]);
        end
        issue_d     = |grant_s;
        issue_idx_d = grant_idx_s;
        count_d     = count_q + (IDX_W+1)'(alloc_ack_s) - (IDX_W+1)'(issue_d) - kill_cnt_s;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            src1_tag_q  <= '0;
            src2_tag_q  <= '0;
            src1_rdy_q  <= '0;
            src2_rdy_q  <= '0;
            specmask_q  <= '0;
            age_q       <= '0;
            issue_q     <= 1'b0;
            issue_idx_q <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            src1_tag_q  <= src1_tag_d;
            src2_tag_q  <= src2_tag_d;
            src1_rdy_q  <= src1_rdy_d;
            src2_rdy_q  <= src2_rdy_d;
            specmask_q  <= specmask_d;
            age_q       <= age_d;
            issue_q     <= issue_d;
            issue_idx_q <= issue_idx_d;
            count_q     <= count_d;
        end
    end

    assign alloc_ack = alloc_ack_s;
    assign issue     = issue_q;
    assign issue_idx = issue_idx_q;
    assign count     = count_q;
    assign full      = full_s;

endmodule

// File: tb/tb_brsched_issue.sv
// -----------------------------------------------------------------------------
// tb_brsched_issue
// Directed self-checking bench for brsched_issue (ENTRY_NUM=4, TAG_W=6,
// SPECTAG_LEN=5). Inputs change 1 time unit after the rising edge; outputs
// are sampled there too. Honours BRSCHED_WAKEUP_BYPASS_EN in test_bypass.
// -----------------------------------------------------------------------------
module tb_brsched_issue;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_valid;
    logic       alloc_ack;
    logic [5:0] alloc_src1_tag, alloc_src2_tag;
    logic       alloc_src1_rdy, alloc_src2_rdy;
    logic [4:0] alloc_specmask;
    logic [1:0] wk_valid;
    logic [5:0] wk_tag0, wk_tag1;
    logic       kill_valid;
    logic [4:0] kill_tag;
    logic       clr_valid;
    logic [4:0] clr_tag;
    logic       issue;
    logic [1:0] issue_idx;
    logic [2:0] count;
    logic       full;

    int vectors     = 0;
    int miscompares = 0;

    brsched_issue dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_valid    (alloc_valid),
        .alloc_ack      (alloc_ack),
        .alloc_src1_tag (alloc_src1_tag),
        .alloc_src2_tag (alloc_src2_tag),
        .alloc_src1_rdy (alloc_src1_rdy),
        .alloc_src2_rdy (alloc_src2_rdy),
        .alloc_specmask (alloc_specmask),
        .wk_valid       (wk_valid),
        .wk_tag0        (wk_tag0),
        .wk_tag1        (wk_tag1),
        .kill_valid     (kill_valid),
        .kill_tag       (kill_tag),
        .clr_valid      (clr_valid),
        .clr_tag        (clr_tag),
        .issue          (issue),
        .issue_idx      (issue_idx),
        .count          (count),
        .full           (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        alloc_valid    = 1'b0;
        alloc_src1_tag = 6'd0;
        alloc_src2_tag = 6'd0;
        alloc_src1_rdy = 1'b0;
        alloc_src2_rdy = 1'b0;
        alloc_specmask = 5'b00000;
        wk_valid       = 2'b00;
        wk_tag0        = 6'd0;
        wk_tag1        = 6'd0;
        kill_valid     = 1'b0;
        kill_tag       = 5'b00000;
        clr_valid      = 1'b0;
        clr_tag        = 5'b00000;
    endtask

    task automatic apply_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_alloc(input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2,
                            input logic [4:0] m);
        alloc_valid    = 1'b1;
        alloc_src1_tag = t1;
        alloc_src1_rdy = r1;
        alloc_src2_tag = t2;
        alloc_src2_rdy = r2;
        alloc_specmask = m;
        tick();
        alloc_valid    = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        #1;
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL rst_issue: got %0b want 0", issue); end
        vectors++; if (issue_idx !== 2'd0) begin miscompares++; $display("FAIL rst_idx: got %0d want 0", issue_idx); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %0b want 0", full); end
        tick();
        reset = 1'b0;
        do_alloc(6'd1, 1'b0, 6'd2, 1'b0, 5'b00000);
        do_alloc(6'd3, 1'b0, 6'd4, 1'b0, 5'b00000);
        do_alloc(6'd5, 1'b1, 6'd6, 1'b1, 5'b00000);
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL midrst_fill_count: got %0d want 3", count); end
        tick();
        vectors++; if (issue !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_issue: got %0b want 1", issue); end
        #3;
        reset = 1'b1;
        #1;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", count); end
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL midrst_issue: got %0b want 0", issue); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_age_order();
        int c;
        apply_reset();
        do_alloc(6'd5, 1'b0, 6'd6, 1'b0, 5'b00000);    // A, slot 0
        do_alloc(6'd7, 1'b1, 6'd8, 1'b1, 5'b00000);    // B, slot 1, ready
        tick();
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd1) begin miscompares++; $display("FAIL age_b_first: issue=%0b idx=%0d want 1/1", issue, issue_idx); end
        wk_valid = 2'b11; wk_tag0 = 6'd5; wk_tag1 = 6'd6;
        tick();
        wk_valid = 2'b00;
        c = 0;
        while (issue !== 1'b1 && c < 3) begin tick(); c++; end
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL age_a_second: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
        // Younger op reuses slot 0 while older op sits in slot 1
        do_alloc(6'd20, 1'b0, 6'd21, 1'b1, 5'b00000);  // X, slot 0
        do_alloc(6'd22, 1'b0, 6'd23, 1'b1, 5'b00000);  // Y, slot 1
        wk_valid = 2'b01; wk_tag0 = 6'd20;
        tick();
        wk_valid = 2'b00;
        c = 0;
        while (issue !== 1'b1 && c < 3) begin tick(); c++; end
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL age_x: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
        do_alloc(6'd22, 1'b0, 6'd24, 1'b1, 5'b00000);  // Z, slot 0, younger than Y
        wk_valid = 2'b01; wk_tag0 = 6'd22;
        tick();
        wk_valid = 2'b00;
        c = 0;
        while (issue !== 1'b1 && c < 3) begin tick(); c++; end
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd1) begin miscompares++; $display("FAIL age_y_older: issue=%0b idx=%0d want 1/1", issue, issue_idx); end
        tick();
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL age_z_younger: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL age_drained: count=%0d want 0", count); end
    endtask

    task automatic test_full();
        int c;
        apply_reset();
        do_alloc(6'd20, 1'b0, 6'd30, 1'b1, 5'b00000);
        do_alloc(6'd21, 1'b0, 6'd30, 1'b1, 5'b00000);
        do_alloc(6'd22, 1'b0, 6'd30, 1'b1, 5'b00000);
        do_alloc(6'd23, 1'b0, 6'd30, 1'b1, 5'b00000);
        vectors++; if (full !== 1'b1 || count !== 3'd4) begin miscompares++; $display("FAIL full_set: full=%0b count=%0d want 1/4", full, count); end
        alloc_valid = 1'b1; alloc_src1_tag = 6'd40; alloc_src1_rdy = 1'b1;
        alloc_src2_tag = 6'd41; alloc_src2_rdy = 1'b1; alloc_specmask = 5'b00000;
        wk_valid = 2'b01; wk_tag0 = 6'd20;
        #1;
        vectors++; if (alloc_ack !== 1'b0) begin miscompares++; $display("FAIL full_reject: alloc_ack=%0b want 0", alloc_ack); end
        tick();
        wk_valid = 2'b00;
        c = 0;
        while (issue !== 1'b1 && c < 3) begin tick(); c++; end
        vectors++; if (count !== 3'd3 || full !== 1'b0) begin miscompares++; $display("FAIL full_issue_cycle: count=%0d full=%0b want 3/0", count, full); end
        vectors++; if (alloc_ack !== 1'b1) begin miscompares++; $display("FAIL full_reopen_ack: alloc_ack=%0b want 1", alloc_ack); end
        tick();
        alloc_valid = 1'b0;
        vectors++; if (count !== 3'd4 || full !== 1'b1) begin miscompares++; $display("FAIL full_refill: count=%0d full=%0b want 4/1", count, full); end
    endtask

    task automatic test_kill();
        int c;
        apply_reset();
        do_alloc(6'd31, 1'b0, 6'd1, 1'b1, 5'b00100);   // slot 0, depends on branch 2
        do_alloc(6'd32, 1'b0, 6'd1, 1'b1, 5'b00000);   // slot 1, independent
        do_alloc(6'd33, 1'b1, 6'd1, 1'b1, 5'b00010);   // slot 2, ready, depends on branch 1
        vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL kill_pre_count: count=%0d want 3", count); end
        kill_valid = 1'b1; kill_tag = 5'b00010;
        alloc_valid = 1'b1; alloc_src1_tag = 6'd34; alloc_src1_rdy = 1'b1;
        alloc_src2_tag = 6'd35; alloc_src2_rdy = 1'b1; alloc_specmask = 5'b00010;
        #1;
        vectors++; if (alloc_ack !== 1'b0) begin miscompares++; $display("FAIL kill_alloc_drop: alloc_ack=%0b want 0", alloc_ack); end
        tick();
        kill_valid = 1'b0; alloc_valid = 1'b0;
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL kill_no_issue: issue=%0b want 0", issue); end
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL kill_count: count=%0d want 2", count); end
        clr_valid = 1'b1; clr_tag = 5'b00100;
        tick();
        clr_valid = 1'b0;
        kill_valid = 1'b1; kill_tag = 5'b00100;
        tick();
        kill_valid = 1'b0;
        vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL clr_survive_count: count=%0d want 2", count); end
        wk_valid = 2'b01; wk_tag0 = 6'd31;
        tick();
        wk_valid = 2'b00;
        c = 0;
        while (issue !== 1'b1 && c < 3) begin tick(); c++; end
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL clr_survivor_issue: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_alloc(6'd1, 1'b1, 6'd2, 1'b1, 5'b00000);
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL b2b_min_latency: issue=%0b want 0", issue); end
        do_alloc(6'd3, 1'b1, 6'd4, 1'b1, 5'b00000);
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL b2b_first: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
        do_alloc(6'd5, 1'b1, 6'd6, 1'b1, 5'b00000);
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd1) begin miscompares++; $display("FAIL b2b_second: issue=%0b idx=%0d want 1/1", issue, issue_idx); end
        tick();
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL b2b_third: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL b2b_count: count=%0d want 0", count); end
    endtask

    task automatic test_alloc_wakeup();
        apply_reset();
        wk_valid = 2'b10; wk_tag1 = 6'd12;
        do_alloc(6'd12, 1'b0, 6'd13, 1'b1, 5'b00000);
        wk_valid = 2'b00;
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL allocwk_early: issue=%0b want 0", issue); end
        tick();
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL allocwk_issue: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
    endtask

    task automatic test_bypass();
        apply_reset();
        do_alloc(6'd9, 1'b0, 6'd3, 1'b1, 5'b00000);
        tick();
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL byp_waiting: issue=%0b want 0", issue); end
        wk_valid = 2'b10; wk_tag1 = 6'd9;
        tick();
        wk_valid = 2'b00;
`ifdef BRSCHED_WAKEUP_BYPASS_EN
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL byp_edge_t: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
`else
        vectors++; if (issue !== 1'b0) begin miscompares++; $display("FAIL byp_edge_t: issue=%0b want 0", issue); end
        tick();
        vectors++; if (issue !== 1'b1 || issue_idx !== 2'd0) begin miscompares++; $display("FAIL byp_edge_t1: issue=%0b idx=%0d want 1/0", issue, issue_idx); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_age_order();
        test_full();
        test_kill();
        test_back_to_back();
        test_alloc_wakeup();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/brsched_issue.md
Name: brsched_issue

Overview:
- Age-ordered scheduler for the single branch execution unit.
- Holds up to ENTRY_NUM decoded branch/jump ops waiting for their source operands.
- Listens to result-tag wakeup broadcasts and issues the oldest ready op, at most one per cycle.
- Squashes entries on a branch miss; clears speculation bits on a branch success.

Parameters:
- ENTRY_NUM, 4, number of scheduler slots (power of two, 2..8).
- TAG_W, 6, width of RRF source tags.
- SPECTAG_LEN, 5, width of one-hot speculation tag and dependency mask (shared constant).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  dispatch offers one op.
- alloc_ack  out  1  op accepted this cycle; combinational; equals alloc_valid & ~full & ~alloc_killed.
- alloc_src1_tag, alloc_src2_tag  in  TAG_W each  source tags.
- alloc_src1_rdy, alloc_src2_rdy  in  1 each  sources already available.
- alloc_specmask  in  SPECTAG_LEN  branches this op depends on.
- wk_valid  in  2  two wakeup broadcast ports.
- wk_tag0, wk_tag1  in  TAG_W each  broadcast result tags.
- kill_valid  in  1  branch miss (from the branch unit's prmiss).
- kill_tag  in  SPECTAG_LEN  one-hot tag of the mispredicted branch.
- clr_valid  in  1  branch success (prsuccess).
- clr_tag  in  SPECTAG_LEN  one-hot tag to clear from all masks.
- issue  out  1  registered; drives the execution unit's issue input.
- issue_idx  out  log2(ENTRY_NUM)  slot issued (payload RAM read index).
- count  out  log2(ENTRY_NUM)+1  valid entries.
- full  out  1  count == ENTRY_NUM.

Behaviour:
- Reset (async): all valid bits 0, age matrix 0, issue 0, issue_idx 0, count 0, full 0.
- Per-entry state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, specmask.
- Age: ENTRY_NUM×ENTRY_NUM matrix. On allocation into slot k, row k is set to the current valid vector, marking every live entry older than k.
- Allocation: lowest-index free slot.
  - full is computed from registered state, so alloc while full is rejected even if an issue frees a slot in the same cycle.
- Wakeup: a source becomes ready when wk_valid[p] & (tag == wk_tag_p), for either port. An alloc-cycle source is also compared against both ports.
- Ready entry: valid & src1_rdy & src2_rdy, using registered ready bits.
- Select: the ready entry with no ready older entry in its age row.
  - Registered into issue/issue_idx; the entry is freed at the same edge.
  - Issue latency: 1 cycle after ready. Minimum alloc-to-issue is 2 cycles.
- Kill: any entry with (specmask & kill_tag) != 0 is invalidated at the next edge.
  - Kill has priority over selection: a killed entry is never issued.
  - An incoming op with (alloc_specmask & kill_tag) != 0 is dropped (alloc_killed), and alloc_ack is low.
- Clear: specmask &= ~clr_tag in all entries, including the allocating op.
  - A simultaneous kill and clear with the same tag is illegal; kill wins.
- count update: += alloc_ack, −= issued, −= killed entries, all in the same edge.
  - Invariant: 0 ≤ count ≤ ENTRY_NUM.
- Execution unit is fully pipelined, 1 cycle busy, so there is no backpressure; one issue per cycle is sustained.

Optional Feature:
- BRSCHED_WAKEUP_BYPASS_EN defined: readiness also includes same-cycle wakeup matches.
  - An entry woken in cycle t issues at the edge ending t (latency 0 from wakeup).
  - An alloc'd op with both sources ready is still not selectable until its entry is valid.
- Undefined: readiness uses registered bits only; a wakeup at cycle t gives issue at the earliest edge ending t+1.

Decomposition:
- Shared constants package gains BRSCHED_ENTRY_NUM and BRSCHED_IDX_W.
- SPECTAG_LEN and TAG_W are reused from the existing constants header.
- One sub-module, brsched_oldest_sel: combinational age-matrix oldest-ready picker producing a one-hot grant and an encoded index.

Test Plan:
- Reset mid-operation: fill 3 entries, assert reset asynchronously between clock edges → valid/count/issue are 0 immediately, before the next edge.
- Age order: alloc A (tag deps 5,6 unready), then B (ready) into slots 0 and 1; broadcast tag5 and tag6 at cycle 4 → B issues first (idx 1), then A at cycle 5 (bypass off).
- Full: alloc 4 ops with unready sources → full=1, count=4; 5th alloc_valid → alloc_ack=0; issue one → full=0 next cycle, 5th accepted the cycle after.
- Kill: entries with specmask 00010, 00100, 00000; kill_tag=00010 in the same cycle the first becomes ready → no issue of it, count 3→2; new alloc with mask 00010 in that cycle → alloc_ack=0.
- Clear then kill: clr_tag=00100, then kill_tag=00100 → the previously dependent entry survives.
- Bypass: with BRSCHED_WAKEUP_BYPASS_EN, entry waiting on tag 9, wk_tag1=9 at cycle t → issue=1 after edge t; without the macro → after edge t+1.
